// File: rtl/fetch_seq_pkg.sv
// Shared definitions for the fetch sequencer: default widths, halt opcode, reset PC, state encoding.
// FETCH_SEQ_SINGLE_STEP_EN adds the STEP_WAIT state.
package fetch_seq_pkg;

    localparam int DEF_ADDR_W  = 7;
    localparam int DEF_INSTR_W = 16;
    localparam logic [DEF_INSTR_W-1:0] DEF_HALT_OPCODE = 16'hFFFF;
    localparam logic [DEF_ADDR_W-1:0]  RESET_PC        = '0;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_EXEC      = 3'd2,
`ifdef FETCH_SEQ_SINGLE_STEP_EN
        ST_HALT      = 3'd3,
        ST_STEP_WAIT = 3'd4
`else
        ST_HALT      = 3'd3
`endif
    } state_t;

endpackage

// File: rtl/fetch_sequencer_program_counter.sv
// Program counter: loads either a branch target or the wrap-around increment when enabled.
module program_counter #(
    parameter int               ADDR_W    = 7,
    parameter logic [ADDR_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              branch,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc
);

    // Increment relies on natural truncation to wrap from the top address to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_VAL;
        end else if (load) begin
            pc <= branch ? target : pc + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/execute controller: owns PC and IR, fetches over req/ack, pulses commit strobe.
// Optional single-step mode under FETCH_SEQ_SINGLE_STEP_EN (adds iStep and STEP_WAIT).
//
// state     | meaning
// IDLE      | waiting for iEnable, outputs inactive
// FETCH     | oRomReq high at PC until iRomAck, IR captured on ack
// EXEC      | one-cycle commit strobe and PC update, or halt detection
// HALT      | stopped on halt opcode, left only through Reset
// STEP_WAIT | (single-step build) waiting for an iStep rising edge
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int                 ADDR_W      = DEF_ADDR_W,
    parameter int                 INSTR_W     = DEF_INSTR_W,
    parameter logic [INSTR_W-1:0] HALT_OPCODE = DEF_HALT_OPCODE
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               iEnable,
`ifdef FETCH_SEQ_SINGLE_STEP_EN
    input  logic               iStep,
`endif
    output logic               oRomReq,
    output logic [ADDR_W-1:0]  oRomAddr,
    input  logic               iRomAck,
    input  logic [INSTR_W-1:0] iRomData,
    output logic [INSTR_W-1:0] oInstruction,
    input  logic               iBranchTaken,
    input  logic [ADDR_W-1:0]  iBranchDir,
    output logic               oExecute,
    output logic               oHalted,
    output logic [ADDR_W-1:0]  oPc
);

    state_t             state;
    state_t             state_nxt;
    logic [INSTR_W-1:0] ir;
    logic               ir_load;
    logic               pc_load;
    logic [ADDR_W-1:0]  pc;

    program_counter #(
        .ADDR_W    (ADDR_W),
        .RESET_VAL (ADDR_W'(RESET_PC))
    ) u_pc (
        .clk    (Clock),
        .rst    (Reset),
        .load   (pc_load),
        .branch (iBranchTaken),
        .target (iBranchDir),
        .pc     (pc)
    );

`ifdef FETCH_SEQ_SINGLE_STEP_EN
    logic step_q;
    logic step_rise;

    // A held iStep only counts once; the registered copy blocks repeats.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            step_q <= 1'b0;
        end else begin
            step_q <= iStep;
        end
    end

    assign step_rise = iStep & ~step_q;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= ST_IDLE;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            if (ir_load) begin
                ir <= iRomData;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        oRomReq   = 1'b0;
        oExecute  = 1'b0;
        oHalted   = 1'b0;
        ir_load   = 1'b0;
        pc_load   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (iEnable) begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                oRomReq = 1'b1;
                if (iRomAck) begin
                    ir_load   = 1'b1;
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (ir == HALT_OPCODE) begin
                    state_nxt = ST_HALT;
                end else begin
                    oExecute = 1'b1;
                    pc_load  = 1'b1;
`ifdef FETCH_SEQ_SINGLE_STEP_EN
                    state_nxt = ST_STEP_WAIT;
`else
                    state_nxt = iEnable ? ST_FETCH : ST_IDLE;
`endif
                end
            end
            ST_HALT: begin
                oHalted = 1'b1;
            end
`ifdef FETCH_SEQ_SINGLE_STEP_EN
            ST_STEP_WAIT: begin
                if (step_rise) begin
                    state_nxt = iEnable ? ST_FETCH : ST_IDLE;
                end
            end
`endif
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign oRomAddr     = pc;
    assign oPc          = pc;
    assign oInstruction = ir;

endmodule
